// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, FSM states, arbitration modes and access check for the data-memory arbiter
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    function automatic logic bad_access(input logic we, input logic [2:0] f3, input logic [1:0] a);
        return ((f3 == F3_H || f3 == F3_HU) && a[0])
            || (f3 == F3_W && a != 2'b00)
            || (we && !(f3 inside {F3_B, F3_H, F3_W}))
            || (!we && (f3 inside {3'b011, 3'b110, 3'b111}));
    endfunction

endpackage

// File: rtl/dmem_rr_grant.sv
// dmem_rr_grant: two-requester one-hot grant, round-robin or fixed priority to port 0
module dmem_rr_grant import dmem_pkg::*; #(
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb grant = &req ? ((PRIO_MODE == PRIO_FIXED || last_grant) ? 2'b01 : 2'b10) : req;

    always_ff @(posedge clk)
        if (!rst_n)
            last_grant <= 1'b1;
        else if (adv && |req)
            last_grant <= grant[1];

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter for the single-port data memory; DMEM_ARB_ALIGN_CHK_EN enables the access check
module dmem_arbiter import dmem_pkg::*; #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [2:0]        p0_req_funct3,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_resp_valid,
    output logic [DATA_W-1:0] p0_resp_rdata,
    output logic              p0_resp_err,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [2:0]        p1_req_funct3,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_resp_valid,
    output logic [DATA_W-1:0] p1_resp_rdata,
    output logic              p1_resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t state, state_n;
    logic [1:0] req, grant;
    logic hs, we_q, gid_q, err_q;
    logic [2:0] f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q, rdata_o;
    logic we_s;
    logic [2:0] f3_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] wdata_s;

    assign req = {p1_req_valid, p0_req_valid};
    assign we_s = grant[1] ? p1_req_we : p0_req_we;
    assign f3_s = grant[1] ? p1_req_funct3 : p0_req_funct3;
    assign addr_s = grant[1] ? p1_req_addr : p0_req_addr;
    assign wdata_s = grant[1] ? p1_req_wdata : p0_req_wdata;
    assign mem_funct3 = f3_q;
    assign mem_addr = addr_q;
    assign mem_wdata = wdata_q;

    dmem_rr_grant #(.PRIO_MODE(PRIO_MODE)) u_grant (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .adv(state == IDLE),
        .grant(grant)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            we_q <= 1'b0;
            f3_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            gid_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            if (hs) begin
                we_q <= we_s;
                f3_q <= f3_s;
                addr_q <= addr_s;
                wdata_q <= wdata_s;
                gid_q <= grant[1];
            end
            if (mem_read)
                rdata_q <= mem_rdata;
        end
    end

`ifdef DMEM_ARB_ALIGN_CHK_EN
    always_ff @(posedge clk)
        if (!rst_n)
            err_q <= 1'b0;
        else if (hs)
            err_q <= bad_access(we_s, f3_s, addr_s[1:0]);
`else
    assign err_q = 1'b0;
`endif

    always_comb begin
        hs = state == IDLE && |req;
        state_n = state == IDLE ? (hs ? ACCESS : IDLE) : (state == ACCESS ? RESP : IDLE);
        {p1_req_ready, p0_req_ready} = state == IDLE ? grant : 2'b00;
        mem_read = state == ACCESS && !we_q && !err_q;
        mem_write = state == ACCESS && we_q && !err_q;
        p0_resp_valid = state == RESP && !gid_q;
        p1_resp_valid = state == RESP && gid_q;
        rdata_o = (we_q || err_q) ? '0 : rdata_q;
        p0_resp_rdata = p0_resp_valid ? rdata_o : '0;
        p1_resp_rdata = p1_resp_valid ? rdata_o : '0;
        p0_resp_err = p0_resp_valid && err_q;
        p1_resp_err = p1_resp_valid && err_q;
    end

endmodule
